// File: rtl/sequencer_if.sv
// Bus bundle between the Angstrom sequencer and its neighbours: instruction
// memory, branch unit, ALU flags and register file write enable.
interface sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [15:0]       imem_rdata_i;
    logic              imem_valid_i;
    logic [15:0]       instr_o;
    logic [3:0]        op_o;
    logic              alu_z_i;
    logic              alu_c_i;
    logic              flag_z_o;
    logic              flag_c_o;
    logic              ctrl_jmp_o;
    logic              branch_i;
    logic [ADDR_W-1:0] jmp_target_i;
    logic              reg_we_o;
    logic [2:0]        state_o;
    logic              halted_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_o, op_o, flag_z_o, flag_c_o,
               ctrl_jmp_o, reg_we_o, state_o, halted_o,
        input  imem_rdata_i, imem_valid_i, alu_z_i, alu_c_i, branch_i, jmp_target_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, op_o, flag_z_o, flag_c_o,
               ctrl_jmp_o, reg_we_o, state_o, halted_o,
        output imem_rdata_i, imem_valid_i, alu_z_i, alu_c_i, branch_i, jmp_target_i
    );
endinterface

// File: rtl/sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the Angstrom core.
// Define SEQUENCER_HALT_EN to make opcode 1111 halt the core; otherwise it is a NOP.
module sequencer #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk_i,
    input logic         rst_i,
    sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic              imem_req_q, imem_req_d;
    logic              ctrl_jmp_q, ctrl_jmp_d;
    logic              reg_we_q, reg_we_d;
`ifdef SEQUENCER_HALT_EN
    logic              halted_q, halted_d;
`endif

    function automatic logic is_alu(input logic [3:0] op);
        return op <= 4'd4;
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op >= 4'd5) && (op <= 4'd7);
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        c_d     = c_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_valid_i) begin
                    ir_d    = bus.imem_rdata_i;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (is_alu(ir_q[15:12])) begin
                    z_d     = bus.alu_z_i;
                    c_d     = bus.alu_c_i;
                    state_d = S_WRITEBACK;
                end else if (is_branch(ir_q[15:12])) begin
                    // A taken branch replaces the increment applied during fetch.
                    if (bus.branch_i)
                        pc_d = bus.jmp_target_i;
                    state_d = S_FETCH;
                end else if (ir_q[15:12] == 4'hF) begin
`ifdef SEQUENCER_HALT_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // Moore outputs are decoded from the next state/IR so they register in step with them.
    always_comb begin
        imem_req_d = (state_d == S_FETCH);
        ctrl_jmp_d = (state_d == S_EXECUTE) && is_branch(ir_d[15:12]);
        reg_we_d   = (state_d == S_WRITEBACK);
`ifdef SEQUENCER_HALT_EN
        halted_d   = (state_d == S_HALT);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            imem_req_q <= 1'b1;
            ctrl_jmp_q <= 1'b0;
            reg_we_q   <= 1'b0;
`ifdef SEQUENCER_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            z_q        <= z_d;
            c_q        <= c_d;
            imem_req_q <= imem_req_d;
            ctrl_jmp_q <= ctrl_jmp_d;
            reg_we_q   <= reg_we_d;
`ifdef SEQUENCER_HALT_EN
            halted_q   <= halted_d;
`endif
        end
    end

    assign bus.imem_req_o  = imem_req_q;
    assign bus.imem_addr_o = pc_q;
    assign bus.instr_o     = ir_q;
    assign bus.op_o        = ir_q[15:12];
    assign bus.flag_z_o    = z_q;
    assign bus.flag_c_o    = c_q;
    assign bus.ctrl_jmp_o  = ctrl_jmp_q;
    assign bus.reg_we_o    = reg_we_q;
    assign bus.state_o     = state_q;
`ifdef SEQUENCER_HALT_EN
    assign bus.halted_o    = halted_q;
`else
    assign bus.halted_o    = 1'b0;
`endif
endmodule
